// File: rtl/mac_vector_acc_if.sv
// mac_vector_acc_if: beat input and dot-product result handshake bundle
interface mac_vector_acc_if #(parameter int LANES = 4, parameter int CNT_W = 8);
   logic                in_valid;
   logic                in_ready;
   logic                in_last;
   logic [LANES*32-1:0] data;
   logic [LANES*32-1:0] weight;
   logic [LANES-1:0]    lane_mask;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_data;
   logic [CNT_W-1:0]    out_count;
   modport master (
      output in_valid, in_last, data, weight, lane_mask, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );
   modport slave (
      input  in_valid, in_last, data, weight, lane_mask, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/mac_vector_acc.sv
// mac_vector_acc: multi-lane FP32 multiply, adder-tree reduce and accumulate until in_last
module mac_vector_acc #(
   parameter int LANES = 4,
   parameter int CNT_W = 8
) (
   input logic         clk,
   input logic         rst,
   input logic         clr,
   mac_vector_acc_if.slave io
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

   // Subnormal operands and results flush to signed zero; rounding is nearest-even.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s, g, st, nan, inf, zro;
      logic [47:0] p;
      logic [9:0]  e;
      logic [23:0] m;
      s   = a[31] ^ b[31];
      nan = (&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]);
      inf = &a[30:23] || &b[30:23];
      zro = a[30:23] == '0 || b[30:23] == '0;
      p   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e   = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'd0, p[47]};
      m   = {1'b0, p[47] ? p[46:24] : p[45:23]};
      g   = p[47] ? p[23] : p[22];
      st  = p[47] ? |p[22:0] : |p[21:0];
      m   = m + {23'd0, g && (st || m[0])};
      e   = e + {9'd0, m[23]};
      return nan || (inf && zro) ? QNAN :
             inf                 ? {s, 8'hff, 23'd0} :
             zro || e[9] || e == '0 ? {s, 31'd0} :
             e >= 10'd255        ? {s, 8'hff, 23'd0} :
                                   {s, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [26:0] mx, my;
      logic [27:0] n;
      logic [9:0]  e;
      logic [7:0]  d;
      logic [23:0] m;
      logic        nan, g, st;
      nan = (&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]) ||
            (&a[30:23] && &b[30:23] && a[31] != b[31]);
      x   = a[30:0] >= b[30:0] ? a : b;
      y   = a[30:0] >= b[30:0] ? b : a;
      d   = x[30:23] - y[30:23];
      mx  = {1'b1, x[22:0], 3'b0};
      my  = {1'b1, y[22:0], 3'b0};
      // Alignment keeps a sticky bit so rounding sees every shifted-out one.
      my  = d > 8'd26 ? 27'd1 : (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
      n   = x[31] == y[31] ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
      e   = {2'b0, x[30:23]};
      if (n[27]) begin
         n = {1'b0, n[27:2], n[1] | n[0]};
         e = e + 10'd1;
      end
      for (int i = 0; i < 26; i++)
         if (!n[26] && n != '0) begin
            n = n << 1;
            e = e - 10'd1;
         end
      m  = {1'b0, n[25:3]};
      g  = n[2];
      st = |n[1:0];
      m  = m + {23'd0, g && (st || m[0])};
      e  = e + {9'd0, m[23]};
      return nan                ? QNAN :
             &x[30:23]          ? x :
             y[30:23] == '0     ? (x[30:23] == '0 ? {a[31] & b[31], 31'd0} : x) :
             n == '0            ? 32'd0 :
             e[9] || e == '0    ? {x[31], 31'd0} :
             e >= 10'd255       ? {x[31], 8'hff, 23'd0} :
                                  {x[31], e[7:0], m[22:0]};
   endfunction

   // Pairwise in place: ((l0+l1)+(l2+l3))...; a single lane passes straight through.
   function automatic logic [31:0] tree(input logic [LANES*32-1:0] v);
      logic [LANES*32-1:0] t;
      t = v;
      for (int w = LANES / 2; w >= 1; w = w / 2)
         for (int i = 0; i < w; i++)
            t[32*i +: 32] = fp_add(t[64*i +: 32], t[64*i+32 +: 32]);
      return t[31:0];
   endfunction

   state_t              state_q, state_d;
   logic [LANES*32-1:0] prod_q, prod_d;
   logic                v1_q, v1_d, last1_q, last1_d;
   logic                v2_q, v2_d, last2_q, last2_d;
   logic                out_valid_q, out_valid_d;
   logic [31:0]         sum_q, sum_d, acc_q, acc_d, out_data_q, out_data_d, nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_d, out_count_q, out_count_d, cnt_inc;
   logic                accept, fin;

   assign io.in_ready  = state_q == RUN && !rst;
   assign io.out_valid = out_valid_q;
   assign io.out_data  = out_data_q;
   assign io.out_count = out_count_q;

   always_comb begin
      accept  = io.in_valid && io.in_ready;
      fin     = v2_q && last2_q;
      nxt     = fp_add(acc_q, sum_q);
      cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      prod_d  = '0;
      for (int i = 0; i < LANES; i++)
         prod_d[32*i +: 32] = io.lane_mask[i] ? fp_mul(io.data[32*i +: 32], io.weight[32*i +: 32]) : 32'd0;
      v1_d        = accept;
      last1_d     = accept && io.in_last;
      v2_d        = v1_q;
      last2_d     = last1_q;
      sum_d       = tree(prod_q);
      acc_d       = v2_q ? (last2_q ? 32'd0 : nxt) : acc_q;
      cnt_d       = v2_q ? (last2_q ? '0 : cnt_inc) : cnt_q;
      out_data_d  = fin ? nxt : out_data_q;
      out_count_d = fin ? cnt_inc : out_count_q;
      out_valid_d = fin || (out_valid_q && !(state_q == HOLD && io.out_ready));
      state_d     = state_q == RUN && accept && io.in_last ? DRAIN :
                    state_q == DRAIN && fin                ? HOLD :
                    state_q == HOLD && io.out_ready        ? RUN : state_q;
      if (clr) begin
         state_d     = RUN;
         v1_d        = 1'b0;
         v2_d        = 1'b0;
         acc_d       = 32'd0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         out_data_d  = out_data_q;
         out_count_d = out_count_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         prod_q      <= '0;
         v1_q        <= 1'b0;
         last1_q     <= 1'b0;
         v2_q        <= 1'b0;
         last2_q     <= 1'b0;
         sum_q       <= 32'd0;
         acc_q       <= 32'd0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         prod_q      <= prod_d;
         v1_q        <= v1_d;
         last1_q     <= last1_d;
         v2_q        <= v2_d;
         last2_q     <= last2_d;
         sum_q       <= sum_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end
endmodule
